// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side master: state encoding, default width and
// the read-credit helper used by fifo_reader.
package fifo_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned BufDepth         = 2;

    // True when one more word can be requested without overflowing the output buffer,
    // counting words already stored and in flight, minus the word leaving this cycle.
    function automatic logic read_credit_ok(input logic [1:0] occ,
                                            input logic       inflight,
                                            input logic       pop);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return pending < 3'(BufDepth);
    endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry FIFO-ordered output buffer: the head register drives the stream outputs
// directly, the tail register absorbs the word arriving while the head is stalled.
module fifo_reader_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic                  head_valid_o,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({wr_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = wr_data_i;
                end else begin
                    tail_d = wr_data_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous write and pop: occupancy holds, the queue shifts by one.
                if (occ_q == 2'd1) begin
                    head_d = wr_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = wr_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o        = occ_q;
    assign head_valid_o = (occ_q != 2'd0);
    assign head_data_o  = head_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side master: pops a registered-output FIFO and streams the words on valid/ready.
// Optional transfer counter enabled by defining FIFO_READER_CNT_EN.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    state_e     state_q, state_d;
    logic       inflight_q, inflight_d;
    logic [1:0] occ;
    logic       head_valid;
    logic       pop;

    assign pop     = head_valid & m_ready;
    assign busy    = (occ != 2'd0) | inflight_q;
    assign m_valid = head_valid;

    // Combinational strobe; never asserted in reset or while the FIFO reports empty.
    assign fifo_rd = rst_n & en & ~fifo_empty & (state_q == StRun)
                   & read_credit_ok(occ, inflight_q, pop);

    assign inflight_d = fifo_rd;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = busy ? StHalt : StIdle;
                end
            end
            StHalt: begin
                if (en) begin
                    state_d = StRun;
                end else if (!busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    fifo_reader_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_i        (inflight_q),
        .wr_data_i   (fifo_data),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_valid_o(head_valid),
        .head_data_o (m_data)
    );

`ifdef FIFO_READER_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: upstream FIFO model, word-level reference model
// checked every cycle, directed corner-case sequences and a randomized scenario table.
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int CW = 4;
`ifdef FIFO_READER_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          busy;
    logic [CW-1:0] xfer_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_reader #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
        return CntEn ? 32'(n % (1 << CW)) : 32'd0;
    endfunction

    // Upstream FIFO with registered output and registered empty flag.
    logic [DW-1:0] fq[$];
    always @(posedge clk) begin
        if (fifo_rd && fq.size() > 0) begin
            fifo_data <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Reference model: words taken from the FIFO but not yet delivered, in order.
    logic [DW-1:0] exp_q[$];
    bit inflight_m = 1'b0;
    bit run_m = 1'b0;
    int cnt_m = 0;
    int cyc = 0;
    int pop_total = 0;
    int rd_cyc_q[$];
    int pop_cyc_q[$];

    always @(negedge clk) begin
        int buffered;
        bit v_exp;
        bit pop_exp;
        bit rd_exp;
        cyc++;
        buffered = exp_q.size() - int'(inflight_m);
        v_exp    = (buffered > 0);
        pop_exp  = v_exp && m_ready;
        rd_exp   = rst_n && en && !fifo_empty && run_m && ((exp_q.size() - int'(pop_exp)) < 2);
        chk("m_valid", 32'(m_valid), 32'(v_exp));
        if (v_exp) chk("m_data", 32'(m_data), 32'(exp_q[0]));
        chk("busy", 32'(busy), 32'(exp_q.size() != 0));
        chk("xfer_cnt", 32'(xfer_cnt), cnt_exp(cnt_m));
        chk("fifo_rd", 32'(fifo_rd), 32'(rd_exp));
        if (!rst_n) begin
            exp_q.delete();
            inflight_m = 1'b0;
            run_m      = 1'b0;
            cnt_m      = 0;
        end else begin
            if (pop_exp) begin
                void'(exp_q.pop_front());
                cnt_m++;
                pop_total++;
                pop_cyc_q.push_back(cyc);
            end
            inflight_m = fifo_rd && (fq.size() > 0);
            if (inflight_m) begin
                exp_q.push_back(fq[0]);
                rd_cyc_q.push_back(cyc);
            end
            run_m = en;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        rd_cyc_q.delete();
        pop_cyc_q.delete();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        step(n);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int b;
        b       = 0;
        en      = 1'b1;
        m_ready = 1'b1;
        while ((fq.size() != 0 || busy !== 1'b0) && b < 300) begin
            step(1);
            b++;
        end
        chk("drain_done", 32'(b < 300), 32'd1);
        en = 1'b0;
        step(2);
    endtask

    typedef struct {
        int n_words;
        int en_pct;
        int rdy_pct;
        int push_pct;
        int exp_delivered;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n0;
        int r1;
        int p0;
        int left;
        int guard;

        vecs[0] = '{n_words: 20, en_pct: 100, rdy_pct: 100, push_pct: 100, exp_delivered: 20};
        vecs[1] = '{n_words: 30, en_pct: 80,  rdy_pct: 50,  push_pct: 60,  exp_delivered: 30};
        vecs[2] = '{n_words: 25, en_pct: 60,  rdy_pct: 90,  push_pct: 30,  exp_delivered: 25};
        vecs[3] = '{n_words: 40, en_pct: 100, rdy_pct: 30,  push_pct: 80,  exp_delivered: 40};

        // Reset with en high and a non-empty FIFO: no reads, all outputs cleared.
        rst_n   = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        fq.push_back(8'hAA);
        step(3);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        en    = 1'b0;
        drain();

        // Basic transfer of three words.
        do_reset(2);
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        step(3);
        clear_logs();
        n0      = cyc;
        en      = 1'b1;
        m_ready = 1'b1;
        step(12);
        chk("basic_rd_count", 32'(rd_cyc_q.size()), 32'd3);
        chk("basic_first_rd", 32'(rd_cyc_q[0]), 32'(n0 + 2));
        chk("basic_pop_count", 32'(pop_cyc_q.size()), 32'd3);
        chk("basic_latency", 32'(pop_cyc_q[0]), 32'(rd_cyc_q[0] + 2));
        chk("basic_back_to_back", 32'(pop_cyc_q[2]), 32'(pop_cyc_q[0] + 2));
        chk("basic_xfer_cnt", 32'(xfer_cnt), cnt_exp(3));
        chk("basic_busy_low", 32'(busy), 32'd0);
        en = 1'b0;
        step(2);

        // Backpressure: two reads at most, head held stable.
        m_ready = 1'b0;
        fq.push_back(8'h44);
        fq.push_back(8'h55);
        fq.push_back(8'h66);
        fq.push_back(8'h77);
        step(3);
        clear_logs();
        en = 1'b1;
        step(10);
        chk("bp_rd_count", 32'(rd_cyc_q.size()), 32'd2);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data", 32'(m_data), 32'h44);
        step(3);
        chk("bp_m_data_hold", 32'(m_data), 32'h44);
        chk("bp_rd_count_hold", 32'(rd_cyc_q.size()), 32'd2);
        m_ready = 1'b1;
        step(10);
        chk("bp_pop_count", 32'(pop_cyc_q.size()), 32'd4);
        en = 1'b0;
        step(2);

        // Empty FIFO with en high, then a single word.
        clear_logs();
        en      = 1'b1;
        m_ready = 1'b1;
        step(10);
        chk("empty_no_rd", 32'(rd_cyc_q.size()), 32'd0);
        fq.push_back(8'h5A);
        step(8);
        chk("empty_rd_count", 32'(rd_cyc_q.size()), 32'd1);
        chk("empty_pop_count", 32'(pop_cyc_q.size()), 32'd1);
        chk("empty_latency", 32'(pop_cyc_q[0] - rd_cyc_q[0]), 32'd2);
        en = 1'b0;
        step(2);

        // Disable while a word is in flight.
        for (int i = 0; i < 8; i++) fq.push_back(8'(8'hC0 + i));
        step(3);
        clear_logs();
        en      = 1'b1;
        m_ready = 1'b1;
        step(3);
        en = 1'b0;
        r1 = rd_cyc_q.size();
        step(8);
        chk("halt_reads_before", 32'(r1), 32'd2);
        chk("halt_no_more_rd", 32'(rd_cyc_q.size()), 32'(r1));
        chk("halt_delivered", 32'(pop_cyc_q.size()), 32'(r1));
        chk("halt_busy_low", 32'(busy), 32'd0);
        chk("halt_fifo_left", 32'(fq.size()), 32'd6);
        drain();

        // Randomized scenarios.
        for (int v = 0; v < 4; v++) begin
            p0    = pop_total;
            left  = vecs[v].n_words;
            guard = 0;
            while ((left > 0 || guard < 20) && guard < 600) begin
                if (left > 0 && $urandom_range(0, 99) < 32'(vecs[v].push_pct)) begin
                    fq.push_back(8'($urandom_range(0, 255)));
                    left--;
                end
                en      = ($urandom_range(0, 99) < 32'(vecs[v].en_pct));
                m_ready = ($urandom_range(0, 99) < 32'(vecs[v].rdy_pct));
                step(1);
                guard++;
            end
            drain();
            chk($sformatf("rand%0d_delivered", v), 32'(pop_total - p0),
                32'(vecs[v].exp_delivered));
        end

        // Reset while the buffer is full.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'hE0 + i));
        step(3);
        en = 1'b1;
        step(6);
        chk("rstmid_full_valid", 32'(m_valid), 32'd1);
        chk("rstmid_full_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("rstmid_m_valid", 32'(m_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rstmid_fifo_rd", 32'(fifo_rd), 32'd0);
        rst_n = 1'b1;
        en    = 1'b0;
        step(2);
        chk("rstmid_words_lost", 32'(fq.size()), 32'd2);
        drain();

        // Counter wrap after 17 words with a 4-bit counter.
        do_reset(2);
        clear_logs();
        for (int i = 0; i < 17; i++) fq.push_back(8'(i * 7));
        step(3);
        en      = 1'b1;
        m_ready = 1'b1;
        step(30);
        chk("wrap_pop_count", 32'(pop_cyc_q.size()), 32'd17);
        chk("wrap_xfer_cnt", 32'(xfer_cnt), cnt_exp(17));
        en = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side master for the team's synchronous FIFO (registered `d_out`, `rd`/`empty` strobe interface). It pops words from the FIFO and presents them on a valid/ready stream to a downstream consumer, sustaining one word per cycle. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer. It sits between any `fifo_flag`-style buffer and a stream sink such as a serializer or packet builder.

## Interface
- `DATA_WIDTH`, 8, FIFO word width.
- `CNT_WIDTH`, 16, width of the transfer counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  enables new FIFO reads while high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `d_out`, valid the cycle after an accepted read.
- `fifo_rd`  out  1  FIFO read strobe, combinational.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  high while any word is in flight or buffered.
- `xfer_cnt`  out  CNT_WIDTH  count of accepted output words.

## Operation
- Bookkeeping:
  - `occ` is buffer occupancy, 0..2.
  - `inflight` is 1 if `fifo_rd` was asserted last cycle.
  - `pop` = `m_valid && m_ready`.
- `fifo_rd` = `en && !fifo_empty && state==RUN && (occ + inflight - pop) < 2`. It must never be asserted while `fifo_empty` is high.
- When `inflight` is 1, `fifo_data` is written into the buffer tail at the end of that cycle.
- The buffer is FIFO-ordered.
  - `m_data`/`m_valid` always reflect the head entry.
  - `m_data` must stay stable while `m_valid && !m_ready`.
- A write and a pop in the same cycle keep `occ` unchanged. The buffer never overflows, because the credit rule above guarantees it.
- State machine, 2-bit:
  - IDLE: `busy`=0.
    - Goes to RUN when `en`=1.
  - RUN: reads are issued.
    - Goes to HALT when `en`=0 and (`occ`>0 or `inflight`).
    - Goes to IDLE when `en`=0 and the buffer is clear.
  - HALT: no new reads; in-flight and buffered words are still delivered.
    - Goes to RUN if `en` returns to 1.
    - Goes to IDLE when `occ`==0, `inflight`==0.
- `busy` = (`occ` != 0) || `inflight`.
- `xfer_cnt` increments by 1 on every `pop`, wrapping modulo 2^CNT_WIDTH.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `occ`=0, `inflight`=0, `xfer_cnt`=0, `m_valid`=0, `busy`=0, `m_data`=0. `fifo_rd` is forced 0 while `rst_n` is low.
- Reset mid-operation discards buffered and in-flight words. The upstream FIFO's pointer has already advanced, so those words are lost by design.
- Latency:
  - `fifo_rd` high in cycle N gives `m_valid` high in cycle N+2.
  - From IDLE, `en` rising in cycle N gives the first `fifo_rd` in N+1, at the earliest.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, `fifo_rd` and `m_valid` are both high every cycle.
- Backpressure: with `m_ready`=0, at most 2 reads are issued, after which `fifo_rd` stays 0.
- `fifo_empty` rising: reads stop that same cycle. Words already in flight are still delivered.

## Configuration
- `FIFO_READER_CNT_EN`:
  - Defined: `xfer_cnt` counter is implemented as above.
  - Undefined: counter logic is removed and `xfer_cnt` is tied to 0. The port is kept in both cases.

## Structure
- Shared package `fifo_pkg`:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, HALT=2'd2.
  - Default `DATA_WIDTH`.
- One sub-module, `fifo_reader_buf`: the 2-entry skid buffer, with write port, pop, `occ` output, and head data/valid.

## Test plan
- Basic transfer: reset, FIFO holds 0x11,0x22,0x33, `en`=1, `m_ready`=1.
  - First `m_valid` two cycles after the first `fifo_rd`.
  - Words appear in order on consecutive cycles.
  - `xfer_cnt`=3, `busy` falls the cycle after the last pop.
- Backpressure: FIFO holds 4 words, `m_ready`=0.
  - Exactly 2 `fifo_rd` pulses, then none.
  - `m_data`=first word, held stable.
  - Releasing `m_ready` delivers all 4 in order with no loss.
- Empty FIFO: `fifo_empty`=1 with `en`=1 for 10 cycles, then one word written.
  - No `fifo_rd` while empty.
  - Word delivered 2 cycles after its read.
- Disable mid-stream: drop `en` in the same cycle as a read.
  - State goes to HALT; the in-flight word is still delivered.
  - No further reads; state returns to IDLE.
- Reset mid-operation: `rst_n`=0 with `occ`=2.
  - Next cycle `m_valid`=0, `busy`=0, `xfer_cnt`=0, `fifo_rd`=0.
- Counter wrap: build with `FIFO_READER_CNT_EN` and `CNT_WIDTH`=4, pass 17 words.
  - `xfer_cnt`=1.
  - Without the macro, `xfer_cnt` stays 0.
